// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the multicycle processor control unit.
//   - Opcode encodings carried in IR[15:13].
//   - Control FSM state encoding.
//   - ALU operation codes driven on AluOp.
package proc_pkg;

  // Opcodes (IR[15:13])
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_LD  = 3'b101;
  localparam logic [2:0] OP_ST  = 3'b110;
  localparam logic [2:0] OP_111 = 3'b111;  // jmp or mvnz depending on build

  // ALU operation codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  // Register index of the program counter
  localparam logic [2:0] REG_PC = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_F_ADDR  = 3'd1,
    S_F_WAIT  = 3'd2,
    S_F_LOAD  = 3'd3,
    S_EX1     = 3'd4,
    S_EX2     = 3'd5,
    S_EX_WAIT = 3'd6,
    S_EX3     = 3'd7
  } state_t;

  // True for the three two-operand ALU instructions.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  // AluOp code for an ALU instruction; add for anything else.
  function automatic logic [1:0] alu_code(input logic [2:0] op);
    logic [1:0] c;
    case (op)
      OP_SUB:  c = ALU_SUB;
      OP_AND:  c = ALU_AND;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/proc_control_fsm_dec3to8.sv
// dec3to8: 3-bit register index to 8-bit one-hot select with enable.
//   i_en      in   1  enable; output is all-zero when low
//   i_sel     in   3  register index
//   o_onehot  out  8  one-hot select (bit i_sel set when enabled)
module dec3to8 (
  input  logic       i_en,
  input  logic [2:0] i_sel,
  output logic [7:0] o_onehot
);

  always_comb begin
    o_onehot = 8'h00;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/proc_control_fsm.sv
// proc_control_fsm: multicycle control unit for the 16-bit processor.
// Fetches one instruction through the PC (R7), executes it over a few
// cycles and pulses Done when it retires. All outputs are Moore-style,
// decoded from state, IR and G_nz; while Resetn is low every output is
// forced to 0 except pc_clear.
//
// Build option: PROC_JUMP_EN
//   defined   -> op 111 is jmp  (PC <= R[Y])
//   undefined -> op 111 is mvnz (R[X] <= R[Y] when G != 0)
//
// Parameters
//   DATA_W    datapath / IR width (opcode fields live in IR[15:7])
//   MEM_WAIT  idle cycles between ADDRin and valid DIN (0..7)
// Ports
//   Clock     in   clock, all state on posedge
//   Resetn    in   synchronous active-low reset
//   Run       in   start / continue execution
//   IR        in   instruction register: [15:13] op, [12:10] X, [9:7] Y
//   G_nz      in   G register is non-zero
//   Rin       out  one-hot register write enables (bit 7 = PC load)
//   Rout      out  one-hot bus source select for R0..R7
//   IRin      out  load IR from DIN
//   Ain, Gin  out  load ALU operand A / result G
//   Gout      out  G drives bus
//   DINout    out  DIN drives bus
//   AluOp     out  00 add, 01 sub, 10 and
//   ADDRin    out  load memory address register from bus
//   DOUTin    out  load memory data-out register from bus
//   W_D       out  memory write strobe
//   pc_incr   out  PC increment
//   pc_clear  out  PC clear (asserted while in reset)
//   Done      out  one-cycle pulse: instruction retired
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MEM_WAIT = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] IR,
  input  logic              G_nz,
  output logic [7:0]        Rin,
  output logic [7:0]        Rout,
  output logic              IRin,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic              DINout,
  output logic [1:0]        AluOp,
  output logic              ADDRin,
  output logic              DOUTin,
  output logic              W_D,
  output logic              pc_incr,
  output logic              pc_clear,
  output logic              Done
);

  // The wait state is entered for its first cycle, so the counter loads
  // MEM_WAIT-1 and the state exits once it reads 0.
  localparam int         WAIT_LD_I = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;
  localparam logic [2:0] WAIT_LD   = 3'(WAIT_LD_I);
  localparam bit         HAS_WAIT  = (MEM_WAIT > 0);

  state_t     r_state, w_next;
  logic [2:0] r_wait,  w_wait_nxt;

  logic [2:0] w_op, w_x, w_y;
  logic       w_unused_ir;

  assign w_op        = IR[15:13];
  assign w_x         = IR[12:10];
  assign w_y         = IR[9:7];
  assign w_unused_ir = ^IR[6:0];

  // Raw (pre-reset-gating) control decode
  logic       w_rin_en,  w_rout_en;
  logic [2:0] w_rin_sel, w_rout_sel;
  logic       w_irin, w_ain, w_gin, w_gout, w_dinout;
  logic [1:0] w_aluop;
  logic       w_addrin, w_doutin, w_wd, w_pinc, w_done;

  always_comb begin
    w_next     = r_state;
    w_wait_nxt = r_wait;
    w_rin_en   = 1'b0;
    w_rin_sel  = w_x;
    w_rout_en  = 1'b0;
    w_rout_sel = w_y;
    w_irin     = 1'b0;
    w_ain      = 1'b0;
    w_gin      = 1'b0;
    w_gout     = 1'b0;
    w_dinout   = 1'b0;
    w_aluop    = ALU_ADD;
    w_addrin   = 1'b0;
    w_doutin   = 1'b0;
    w_wd       = 1'b0;
    w_pinc     = 1'b0;
    w_done     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (Run) w_next = S_F_ADDR;
      end

      S_F_ADDR: begin
        w_rout_en  = 1'b1;
        w_rout_sel = REG_PC;
        w_addrin   = 1'b1;
        w_pinc     = 1'b1;
        if (HAS_WAIT) begin
          w_next     = S_F_WAIT;
          w_wait_nxt = WAIT_LD;
        end else begin
          w_next     = S_F_LOAD;
        end
      end

      S_F_WAIT: begin
        if (r_wait == 3'd0) w_next = S_F_LOAD;
        else                w_wait_nxt = r_wait - 3'd1;
      end

      S_F_LOAD: begin
        w_dinout = 1'b1;
        w_irin   = 1'b1;
        w_next   = S_EX1;
      end

      S_EX1: begin
        case (w_op)
          OP_MV: begin
            w_rout_en = 1'b1;
            w_rin_en  = 1'b1;
            w_done    = 1'b1;
          end
          OP_MVI: begin
            // Immediate sits at the word after the instruction: fetch it
            // through the PC and step past it.
            w_rout_en  = 1'b1;
            w_rout_sel = REG_PC;
            w_addrin   = 1'b1;
            w_pinc     = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            w_rout_en  = 1'b1;
            w_rout_sel = w_x;
            w_ain      = 1'b1;
            w_next     = S_EX2;
          end
          OP_LD: begin
            w_rout_en = 1'b1;
            w_addrin  = 1'b1;
          end
          OP_ST: begin
            w_rout_en = 1'b1;
            w_addrin  = 1'b1;
            w_next    = S_EX2;
          end
          default: begin  // OP_111
`ifdef PROC_JUMP_EN
            w_rout_en = 1'b1;
            w_rin_en  = 1'b1;
            w_rin_sel = REG_PC;
`else
            w_rout_en = G_nz;
            w_rin_en  = G_nz;
`endif
            w_done    = 1'b1;
          end
        endcase
        // mvi and ld both wait for memory before the EX3 write-back.
        if (w_op == OP_MVI || w_op == OP_LD) begin
          if (HAS_WAIT) begin
            w_next     = S_EX_WAIT;
            w_wait_nxt = WAIT_LD;
          end else begin
            w_next     = S_EX3;
          end
        end
      end

      S_EX2: begin
        if (w_op == OP_ST) begin
          w_rout_en  = 1'b1;
          w_rout_sel = w_x;
          w_doutin   = 1'b1;
          w_wd       = 1'b1;
          w_done     = 1'b1;
        end else if (is_alu_op(w_op)) begin
          w_rout_en = 1'b1;
          w_gin     = 1'b1;
          w_aluop   = alu_code(w_op);
          w_next    = S_EX3;
        end else begin
          w_next    = S_IDLE;  // unreachable for a stable IR
        end
      end

      S_EX_WAIT: begin
        if (r_wait == 3'd0) w_next = S_EX3;
        else                w_wait_nxt = r_wait - 3'd1;
      end

      S_EX3: begin
        w_rin_en = 1'b1;
        if (is_alu_op(w_op)) w_gout   = 1'b1;
        else                 w_dinout = 1'b1;
        w_done   = 1'b1;
      end

      default: w_next = S_IDLE;
    endcase

    // Run is sampled at retirement to chain straight into the next fetch.
    if (w_done) w_next = Run ? S_F_ADDR : S_IDLE;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_wait  <= 3'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
    end
  end

  // Reset gates the decoders directly so a write in flight is dropped.
  logic [7:0] w_rin_oh, w_rout_oh;

  dec3to8 u_dec_rin (
    .i_en     (w_rin_en & Resetn),
    .i_sel    (w_rin_sel),
    .o_onehot (w_rin_oh)
  );

  dec3to8 u_dec_rout (
    .i_en     (w_rout_en & Resetn),
    .i_sel    (w_rout_sel),
    .o_onehot (w_rout_oh)
  );

  assign Rin      = w_rin_oh;
  assign Rout     = w_rout_oh;
  assign IRin     = Resetn & w_irin;
  assign Ain      = Resetn & w_ain;
  assign Gin      = Resetn & w_gin;
  assign Gout     = Resetn & w_gout;
  assign DINout   = Resetn & w_dinout;
  assign AluOp    = Resetn ? w_aluop : 2'b00;
  assign ADDRin   = Resetn & w_addrin;
  assign DOUTin   = Resetn & w_doutin;
  assign W_D      = Resetn & w_wd;
  assign pc_incr  = Resetn & w_pinc;
  assign pc_clear = ~Resetn;
  assign Done     = Resetn & w_done;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm. The reference model expands each instruction
// into the list of per-cycle output vectors the instruction must produce
// and checks the DUT against the head of that list every cycle. The bench
// also plays the IR register: IR takes the next instruction word after a
// cycle with IRin high.
module tb_proc_control_fsm;

  localparam int MW = 1;

  logic        Clock, Resetn, Run, G_nz;
  logic [15:0] IR;
  logic [7:0]  Rin, Rout;
  logic        IRin, Ain, Gin, Gout, DINout, ADDRin, DOUTin, W_D;
  logic        pc_incr, pc_clear, Done;
  logic [1:0]  AluOp;

  proc_control_fsm #(.DATA_W(16), .MEM_WAIT(MW)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR), .G_nz(G_nz),
    .Rin(Rin), .Rout(Rout), .IRin(IRin), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .DINout(DINout), .AluOp(AluOp), .ADDRin(ADDRin), .DOUTin(DOUTin),
    .W_D(W_D), .pc_incr(pc_incr), .pc_clear(pc_clear), .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] rin, rout;
    logic       irin, ain, gin, gout, dinout;
    logic [1:0] aluop;
    logic       addrin, doutin, wd, pinc, pclr, done;
  } ov_t;

  typedef struct {
    ov_t o;
    bit  cond;   // mvnz: rin/rout only when G_nz
    bit  fload;  // IR is loaded at the end of this cycle
  } ent_t;

  localparam bit [10:0] F_IRIN = 11'h400, F_AIN  = 11'h200, F_GIN  = 11'h100,
                        F_GOUT = 11'h080, F_DIN  = 11'h040, F_ADDR = 11'h020,
                        F_DOUT = 11'h010, F_WD   = 11'h008, F_PINC = 11'h004,
                        F_PCLR = 11'h002, F_DONE = 11'h001;

  ov_t dut_o;
  assign dut_o = {Rin, Rout, IRin, Ain, Gin, Gout, DINout, AluOp,
                  ADDRin, DOUTin, W_D, pc_incr, pc_clear, Done};

  int n_vec = 0;
  int n_err = 0;

  function automatic ov_t mk(logic [7:0] rin, logic [7:0] rout,
                             logic [1:0] alu, bit [10:0] f);
    ov_t r;
    r = '0;
    r.rin = rin; r.rout = rout; r.aluop = alu;
    {r.irin, r.ain, r.gin, r.gout, r.dinout, r.addrin,
     r.doutin, r.wd, r.pinc, r.pclr, r.done} = f;
    return r;
  endfunction

  function automatic logic [7:0] oh(logic [2:0] i);
    return 8'h01 << i;
  endfunction

  task automatic chk(string nm, ov_t act, ov_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got rin=%h rout=%h flags=%b alu=%b want rin=%h rout=%h flags=%b alu=%b",
               nm, $time, act.rin, act.rout,
               {act.irin, act.ain, act.gin, act.gout, act.dinout, act.addrin,
                act.doutin, act.wd, act.pinc, act.pclr, act.done}, act.aluop,
               exp.rin, exp.rout,
               {exp.irin, exp.ain, exp.gin, exp.gout, exp.dinout, exp.addrin,
                exp.doutin, exp.wd, exp.pinc, exp.pclr, exp.done}, exp.aluop);
    end
  endtask

  // ---------------- reference model ----------------
  ent_t q[$];
  bit   need_exec = 0;

  function automatic void push(ov_t o, bit c, bit f);
    ent_t e;
    e.o = o; e.cond = c; e.fload = f;
    q.push_back(e);
  endfunction

  function automatic void push_waits();
    for (int i = 0; i < MW; i++) push('0, 0, 0);
  endfunction

  function automatic void push_fetch();
    push(mk(8'h00, 8'h80, 2'b00, F_ADDR | F_PINC), 0, 0);
    push_waits();
    push(mk(8'h00, 8'h00, 2'b00, F_DIN | F_IRIN), 0, 1);
  endfunction

  function automatic void push_exec(logic [15:0] ir);
    logic [2:0] op, x, y;
    op = ir[15:13]; x = ir[12:10]; y = ir[9:7];
    case (op)
      3'd0: push(mk(oh(x), oh(y), 2'b00, F_DONE), 0, 0);
      3'd1: begin
        push(mk(8'h00, 8'h80, 2'b00, F_ADDR | F_PINC), 0, 0);
        push_waits();
        push(mk(oh(x), 8'h00, 2'b00, F_DIN | F_DONE), 0, 0);
      end
      3'd2, 3'd3, 3'd4: begin
        push(mk(8'h00, oh(x), 2'b00, F_AIN), 0, 0);
        push(mk(8'h00, oh(y), (op == 3'd2) ? 2'b00 : (op == 3'd3) ? 2'b01 : 2'b10,
                F_GIN), 0, 0);
        push(mk(oh(x), 8'h00, 2'b00, F_GOUT | F_DONE), 0, 0);
      end
      3'd5: begin
        push(mk(8'h00, oh(y), 2'b00, F_ADDR), 0, 0);
        push_waits();
        push(mk(oh(x), 8'h00, 2'b00, F_DIN | F_DONE), 0, 0);
      end
      3'd6: begin
        push(mk(8'h00, oh(y), 2'b00, F_ADDR), 0, 0);
        push(mk(8'h00, oh(x), 2'b00, F_DOUT | F_WD | F_DONE), 0, 0);
      end
      default: begin
`ifdef PROC_JUMP_EN
        push(mk(8'h80, oh(y), 2'b00, F_DONE), 0, 0);
`else
        push(mk(oh(x), oh(y), 2'b00, F_DONE), 1, 0);
`endif
      end
    endcase
  endfunction

  always @(negedge Clock) begin
    ov_t  exp;
    ent_t e;
    if (need_exec) begin
      push_exec(IR);
      need_exec = 0;
    end
    if (!Resetn)            exp = mk(8'h00, 8'h00, 2'b00, F_PCLR);
    else if (q.size() == 0) exp = '0;
    else begin
      exp = q[0].o;
      if (q[0].cond && !G_nz) begin
        exp.rin  = 8'h00;
        exp.rout = 8'h00;
      end
    end
    chk("model", dut_o, exp);
    // advance the model by the edge that follows
    if (!Resetn) begin
      q.delete();
      need_exec = 0;
    end else if (q.size() == 0) begin
      if (Run) push_fetch();
    end else begin
      e = q.pop_front();
      if (e.fload) need_exec = 1;
      if (e.o.done && Run) push_fetch();
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] nxt_ir;

  task automatic tick_chk(string nm, bit do_chk, ov_t e);
    logic ld;
    @(negedge Clock);
    ld = IRin;
    if (do_chk) chk(nm, dut_o, e);
    @(posedge Clock);
    #1;
    if (ld) IR = nxt_ir;
  endtask

  task automatic tick();
    tick_chk("", 0, '0);
  endtask

  task automatic fetch_chk(string nm);
    tick_chk({nm, "_faddr"}, 1, mk(8'h00, 8'h80, 2'b00, F_ADDR | F_PINC));
    for (int i = 0; i < MW; i++) tick_chk({nm, "_fwait"}, 1, '0);
    tick_chk({nm, "_fload"}, 1, mk(8'h00, 8'h00, 2'b00, F_DIN | F_IRIN));
  endtask

  initial begin
    Resetn = 1'b0; Run = 1'b0; G_nz = 1'b0; IR = 16'h0000; nxt_ir = 16'h0000;

    tick_chk("rst0", 1, mk(8'h00, 8'h00, 2'b00, F_PCLR));
    tick_chk("rst1", 1, mk(8'h00, 8'h00, 2'b00, F_PCLR));
    Resetn = 1'b1;
    tick_chk("idle0", 1, '0);
    tick_chk("idle1", 1, '0);

    // add R2,R5
    nxt_ir = 16'h4A80; Run = 1'b1;
    tick_chk("add_idle", 1, '0);
    Run = 1'b0;  // not sampled again until Done
    fetch_chk("add");
    tick_chk("add_ex1", 1, mk(8'h00, 8'h04, 2'b00, F_AIN));
    tick_chk("add_ex2", 1, mk(8'h00, 8'h20, 2'b00, F_GIN));
    tick_chk("add_ex3", 1, mk(8'h04, 8'h00, 2'b00, F_GOUT | F_DONE));
    tick_chk("add_idle_held", 1, '0);
    tick_chk("add_idle_held2", 1, '0);

    // st R1,[R3]
    nxt_ir = 16'hC580; Run = 1'b1;
    tick_chk("st_idle", 1, '0);
    Run = 1'b0;
    fetch_chk("st");
    tick_chk("st_ex1", 1, mk(8'h00, 8'h08, 2'b00, F_ADDR));
    tick_chk("st_ex2", 1, mk(8'h00, 8'h02, 2'b00, F_DOUT | F_WD | F_DONE));
    tick_chk("st_idle_after", 1, '0);

    // op 111, Y=4, X=0, with G_nz low then high
    for (int g = 0; g < 2; g++) begin
      nxt_ir = 16'hE200; Run = 1'b1;
      tick_chk("op7_idle", 1, '0);
      Run = 1'b0;
      fetch_chk("op7");
      G_nz = g[0];
`ifdef PROC_JUMP_EN
      tick_chk("jmp_ex1", 1, mk(8'h80, 8'h10, 2'b00, F_DONE));
`else
      if (g == 0) tick_chk("mvnz_g0_ex1", 1, mk(8'h00, 8'h00, 2'b00, F_DONE));
      else        tick_chk("mvnz_g1_ex1", 1, mk(8'h01, 8'h10, 2'b00, F_DONE));
`endif
      G_nz = 1'b0;
      tick_chk("op7_idle_after", 1, '0);
    end

    // sub R1,R2 abandoned by reset in EX2
    nxt_ir = 16'h6500; Run = 1'b1;
    tick_chk("sub_idle", 1, '0);
    Run = 1'b0;
    fetch_chk("sub");
    tick_chk("sub_ex1", 1, mk(8'h00, 8'h02, 2'b00, F_AIN));
    Resetn = 1'b0; Run = 1'b1;
    tick_chk("sub_ex2_rst", 1, mk(8'h00, 8'h00, 2'b00, F_PCLR));
    Resetn = 1'b1; Run = 1'b0;
    tick_chk("sub_post_rst_idle", 1, '0);
    tick_chk("sub_post_rst_idle2", 1, '0);

    // randomized traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      Resetn = ($urandom_range(0, 99) != 0);
      Run    = ($urandom_range(0, 3) != 0);
      G_nz   = $urandom_range(0, 1) != 0;
      nxt_ir = 16'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
